// File: rtl/food_spawner.sv
// rtl/food_spawner.sv - places food off the snake body using a free-running LFSR and flags eats
// Candidates are checked against one full head-to-tail scan of the body stream.
module food_spawner #(
    parameter int          GAME_WIDTH  = 30,
    parameter int          GAME_HEIGHT = 14,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] i_pos_x,
    input  logic [3:0] i_pos_y,
    input  logic       i_pos_first,
    input  logic       i_pos_last,
    input  logic       i_pos_valid,
    output logic       o_eat,
    output logic [4:0] o_food_x,
    output logic [3:0] o_food_y,
    output logic       o_food_valid
);

    typedef enum logic [1:0] {SEEK, CHECK, PLACED} state_t;

    localparam logic [4:0] MAX_X = 5'(GAME_WIDTH);
    localparam logic [3:0] MAX_Y = 4'(GAME_HEIGHT);

    state_t      state, state_n;
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic        clash, clash_n;
    logic [4:0]  cand_x, cand_x_n, food_x_n;
    logic [3:0]  cand_y, cand_y_n, food_y_n;
    logic        eat_n;
    logic [4:0]  cx;
    logic [3:0]  cy;
    logic        cand_ok, hit_new, hit_cand, hit_food;

    // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form
    assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign cx       = lfsr[4:0];
    assign cy       = lfsr[11:8];
    assign cand_ok  = (cx >= 5'd1) && (cx <= MAX_X) && (cy >= 4'd1) && (cy <= MAX_Y);
    assign hit_new  = (i_pos_x == cx) && (i_pos_y == cy);
    assign hit_cand = (i_pos_x == cand_x) && (i_pos_y == cand_y);
    assign hit_food = (i_pos_x == o_food_x) && (i_pos_y == o_food_y);

    always_comb begin
        state_n  = state;
        clash_n  = clash;
        cand_x_n = cand_x;
        cand_y_n = cand_y;
        food_x_n = o_food_x;
        food_y_n = o_food_y;
        eat_n    = 1'b0;
        case (state)
            SEEK, CHECK: begin
                if (i_pos_valid) begin
                    // A head beat always (re)starts the check, even mid-scan
                    if (i_pos_first) begin
                        if (cand_ok) begin
                            if (i_pos_last) begin
                                clash_n = 1'b0;
                                if (hit_new) begin
                                    state_n = SEEK;
                                end else begin
                                    state_n  = PLACED;
                                    food_x_n = cx;
                                    food_y_n = cy;
                                end
                            end else begin
                                cand_x_n = cx;
                                cand_y_n = cy;
                                clash_n  = hit_new;
                                state_n  = CHECK;
                            end
                        end else begin
                            clash_n = 1'b0;
                            state_n = SEEK;
                        end
                    end else if (state == CHECK) begin
                        if (i_pos_last) begin
                            clash_n = 1'b0;
                            if (clash || hit_cand) begin
                                state_n = SEEK;
                            end else begin
                                state_n  = PLACED;
                                food_x_n = cand_x;
                                food_y_n = cand_y;
                            end
                        end else begin
                            clash_n = clash | hit_cand;
                        end
                    end
                end
            end
            PLACED: begin
                if (i_pos_valid && i_pos_first && hit_food) begin
                    eat_n   = 1'b1;
                    state_n = SEEK;
                end
            end
            default: state_n = SEEK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SEEK;
            lfsr         <= LFSR_SEED;
            clash        <= 1'b0;
            cand_x       <= 5'd0;
            cand_y       <= 4'd0;
            o_eat        <= 1'b0;
            o_food_valid <= 1'b0;
            o_food_x     <= 5'd0;
            o_food_y     <= 4'd0;
        end else begin
            state        <= state_n;
            lfsr         <= {lfsr_fb, lfsr[15:1]};
            clash        <= clash_n;
            cand_x       <= cand_x_n;
            cand_y       <= cand_y_n;
            o_eat        <= eat_n;
            o_food_valid <= (state_n == PLACED);
            o_food_x     <= food_x_n;
            o_food_y     <= food_y_n;
        end
    end

endmodule

// File: tb/tb_food_spawner.sv
// tb/tb_food_spawner.sv - randomized scoreboard bench for food_spawner against a scan-list model
module tb_food_spawner;

    localparam int          GW   = 30;
    localparam int          GH   = 14;
    localparam logic [15:0] SEED = 16'h090F;   // first candidate is (15,9)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] pos_x = 5'd0;
    logic [3:0] pos_y = 4'd0;
    logic       pos_first = 1'b0;
    logic       pos_last = 1'b0;
    logic       pos_valid = 1'b0;
    logic       eat;
    logic [4:0] food_x;
    logic [3:0] food_y;
    logic       food_valid;

    food_spawner #(.GAME_WIDTH(GW), .GAME_HEIGHT(GH), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst),
        .i_pos_x(pos_x), .i_pos_y(pos_y),
        .i_pos_first(pos_first), .i_pos_last(pos_last), .i_pos_valid(pos_valid),
        .o_eat(eat), .o_food_x(food_x), .o_food_y(food_y), .o_food_valid(food_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       eat;
        logic       valid;
        logic [4:0] x;
        logic [3:0] y;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   eats_seen = 0;
    int   places_seen = 0;

    // Reference model: remembers the whole current scan and searches it at the tail
    int   m_lfsr;
    bit   m_placed, m_scanning;
    int   m_fx, m_fy, m_cx, m_cy;
    int   m_body_x[$];
    int   m_body_y[$];

    task automatic model_edge();
        exp_t e;
        int   cx, cy;
        bit   hit;
        if (rst) begin
            m_lfsr = SEED; m_placed = 0; m_scanning = 0;
            m_fx = 0; m_fy = 0;
            m_body_x.delete(); m_body_y.delete();
            e.eat = 0; e.valid = 0; e.x = 0; e.y = 0;
            exp_q.push_back(e);
            return;
        end
        cx = m_lfsr % 32;
        cy = (m_lfsr / 256) % 16;
        e.eat = 0;
        if (pos_valid) begin
            if (m_placed) begin
                if (pos_first && pos_x == m_fx && pos_y == m_fy) begin
                    e.eat = 1;
                    m_placed = 0;
                    eats_seen++;
                end
            end else begin
                if (pos_first) begin
                    m_scanning = (cx >= 1 && cx <= GW && cy >= 1 && cy <= GH);
                    m_cx = cx; m_cy = cy;
                    m_body_x.delete(); m_body_y.delete();
                end
                if (m_scanning) begin
                    m_body_x.push_back(pos_x);
                    m_body_y.push_back(pos_y);
                    if (pos_last) begin
                        m_scanning = 0;
                        hit = 0;
                        foreach (m_body_x[i])
                            if (m_body_x[i] == m_cx && m_body_y[i] == m_cy) hit = 1;
                        if (!hit) begin
                            m_placed = 1; m_fx = m_cx; m_fy = m_cy;
                            places_seen++;
                        end
                    end
                end
            end
        end
        m_lfsr = (m_lfsr >> 1) |
                 ((((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15);
        e.valid = m_placed;
        e.x = 5'(m_fx);
        e.y = 4'(m_fy);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic v, input logic f, input logic l,
                        input int x, input int y);
        rst = r; pos_valid = v; pos_first = f; pos_last = l;
        pos_x = 5'(x); pos_y = 4'(y);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic scan3(input int hx, input int hy);
        step(0, 1, 1, 0, hx, hy);
        step(0, 1, 0, 0, 15, 8);
        step(0, 1, 0, 1, 15, 9);
    endtask

    // Monitor: compares every registered output cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (eat !== e.eat || food_valid !== e.valid || food_x !== e.x || food_y !== e.y) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t: got eat=%b valid=%b food=(%0d,%0d) want eat=%b valid=%b food=(%0d,%0d)",
                             $time, eat, food_valid, food_x, food_y, e.eat, e.valid, e.x, e.y);
                end
                if (food_valid === 1'b1 && (food_x < 1 || food_x > GW || food_y < 1 || food_y > GH)) begin
                    miscompares++;
                    $display("FAIL food_range t=%0t: got (%0d,%0d) want inside 1..%0d x 1..%0d",
                             $time, food_x, food_y, GW, GH);
                end
            end
        end
    end

    initial begin
        int n;
        // Reset with random stream activity
        for (int i = 0; i < 3; i++)
            step(1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom % 32, $urandom % 16);
        // First scan clashes on (15,9); later scans place somewhere off-body
        scan3(15, 7);
        if (m_placed) begin
            miscompares++;
            $display("FAIL clash_model: got placed=1 want placed=0 after seeded clash scan");
        end
        for (int i = 0; i < 30; i++) scan3(15, 7);
        // Eat: head onto the food, then repeat that head
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (!m_placed && n < 200) begin
                scan3(15, 7);
                n++;
            end
            if (!m_placed) begin
                miscompares++;
                $display("FAIL placement_timeout: got no placement want placement within 200 scans");
            end else begin
                scan3(m_fx, m_fy);
                for (int j = 0; j < 2; j++) scan3(m_fx == 0 ? 1 : m_fx, m_fy);
            end
        end
        // Single-beat scans separated by invalid gaps
        for (int i = 0; i < 300; i++) begin
            n = $urandom % 3;
            for (int j = 0; j < n; j++)
                step(0, 0, 1'($urandom), 1'($urandom), $urandom % 32, $urandom % 16);
            if (m_placed && ($urandom % 3 == 0))
                step(0, 1, 1, 1, m_fx, m_fy);
            else
                step(0, 1, 1, 1, $urandom % 32, $urandom % 16);
        end
        // Reset in the middle of a check scan, then fresh scans
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 0, 15, 7);
            step(0, 1, 0, 0, 15, 8);
            step(1, 1, 0, 0, 15, 8);
            step(0, 1, 0, 1, 15, 9);
            for (int j = 0; j < 4; j++) scan3(15, 7);
        end
        // Random soak
        for (int i = 0; i < 10000; i++) begin
            if (m_placed && ($urandom % 8 == 0))
                step(0, 1, 1, 1'($urandom), m_fx, m_fy);
            else
                step($urandom % 500 == 0, ($urandom % 4) != 0, ($urandom % 4) == 0,
                     ($urandom % 4) == 0, $urandom % 32, $urandom % 16);
        end
        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        if (eats_seen == 0 || places_seen == 0) begin
            miscompares++;
            $display("FAIL coverage: got eats=%0d places=%0d want both nonzero", eats_seen, places_seen);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
